// File: rtl/f1_reaction_timer.sv
`default_nettype none
// ============================================================================
//  Module      : f1_reaction_timer
//  Description : F1 start-light sequencer and reaction timer. Lights the start
//                LEDs one per step, holds them for a pseudo-random delay, then
//                extinguishes them and measures the player's reaction in ms.
//                Includes false-start detection, a timeout and a best-time
//                register.
//  Revision    : 1.0 - initial release
// ============================================================================
module f1_reaction_timer #(
  parameter int          N_LIGHTS     = 5,
  parameter int          STEP_MS      = 500,
  parameter int          MIN_DELAY_MS = 200,
  parameter logic [13:0] DELAY_MASK   = 14'h0FFF,
  parameter int          RT_W         = 14
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                tick_ms,
  input  logic                trigger,
  output logic [N_LIGHTS-1:0] ledr,
  output logic [RT_W-1:0]     react_ms,
  output logic                result_valid,
  output logic [RT_W-1:0]     best_ms,
  output logic                false_start,
  output logic                timed_out,
  output logic                busy,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LIGHTS = 3'd1,
    ST_DELAY  = 3'd2,
    ST_TIMING = 3'd3,
    ST_RESULT = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [RT_W-1:0]     MAX_REACT   = '1;
  localparam logic [N_LIGHTS-1:0] ALL_LIT     = '1;
  localparam logic [N_LIGHTS-1:0] LIGHT_FIRST = N_LIGHTS'(1);
  localparam logic [15:0]         STEP_TGT    = 16'(STEP_MS);
  localparam logic [31:0]         MIN_HOLD    = 32'(MIN_DELAY_MS);

  state_t              state_q, state_d;
  logic                trigger_q;
  logic [13:0]         lfsr_q, lfsr_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic [31:0]         hold_cnt_q, hold_cnt_d;
  logic [31:0]         hold_target_q, hold_target_d;
  logic [RT_W-1:0]     react_cnt_q, react_cnt_d;
  logic [N_LIGHTS-1:0] ledr_q, ledr_d;
  logic [RT_W-1:0]     react_ms_q, react_ms_d;
  logic                result_valid_q, result_valid_d;
  logic [RT_W-1:0]     best_ms_q, best_ms_d;
  logic                timed_out_q, timed_out_d;

  logic                press;
  logic [N_LIGHTS-1:0] ledr_shift;
  logic [15:0]         step_inc;
  logic [31:0]         hold_inc;
  logic [RT_W-1:0]     react_inc;

  // One press per rising edge of the (already synchronised) button level.
  assign press     = trigger & ~trigger_q;
  assign step_inc  = step_cnt_q + 16'd1;
  assign hold_inc  = hold_cnt_q + 32'd1;
  assign react_inc = react_cnt_q + {{(RT_W-1){1'b0}}, 1'b1};

  // Next light pattern: shift in another lit LED above the ones already on.
  generate
    if (N_LIGHTS == 1) begin : g_single_light
      assign ledr_shift = 1'b1;
    end else begin : g_multi_light
      assign ledr_shift = {ledr_q[N_LIGHTS-2:0], 1'b1};
    end
  endgenerate

  // Free-running 14-bit Fibonacci LFSR supplying the random part of the hold.
  always_comb begin
    lfsr_d = {lfsr_q[12:0], lfsr_q[13] ^ lfsr_q[4] ^ lfsr_q[2] ^ lfsr_q[0]};
  end

  // Sequencer next-state and datapath updates; a press always wins over a tick.
  always_comb begin
    state_d        = state_q;
    step_cnt_d     = step_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    hold_target_d  = hold_target_q;
    react_cnt_d    = react_cnt_q;
    ledr_d         = ledr_q;
    react_ms_d     = react_ms_q;
    result_valid_d = 1'b0;
    best_ms_d      = best_ms_q;
    timed_out_d    = timed_out_q;

    unique case (state_q)
      ST_IDLE: begin
        ledr_d = '0;
        if (press) begin
          state_d    = ST_LIGHTS;
          step_cnt_d = 16'd0;
          ledr_d     = LIGHT_FIRST;
        end
      end

      ST_LIGHTS: begin
        if (press) begin
          state_d = ST_FAULT;
          ledr_d  = '0;
        end else if (tick_ms) begin
          if (step_inc == STEP_TGT) begin
            step_cnt_d = 16'd0;
            if (ledr_q == ALL_LIT) begin
              // Every light is on: start the hold with a freshly drawn delay.
              state_d       = ST_DELAY;
              hold_cnt_d    = 32'd0;
              hold_target_d = MIN_HOLD + {18'd0, lfsr_q & DELAY_MASK};
            end else begin
              ledr_d = ledr_shift;
            end
          end else begin
            step_cnt_d = step_inc;
          end
        end
      end

      ST_DELAY: begin
        if (press) begin
          state_d = ST_FAULT;
          ledr_d  = '0;
        end else if (tick_ms) begin
          // ">=" also covers a zero target: leave on the first tick.
          if (hold_inc >= hold_target_q) begin
            state_d     = ST_TIMING;
            ledr_d      = '0;
            react_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
      end

      ST_TIMING: begin
        if (press) begin
          // A tick landing on the press cycle is deliberately not counted.
          state_d        = ST_RESULT;
          react_ms_d     = react_cnt_q;
          result_valid_d = 1'b1;
          timed_out_d    = 1'b0;
          if (react_cnt_q < best_ms_q) begin
            best_ms_d = react_cnt_q;
          end
        end else if (tick_ms) begin
          if (react_inc == MAX_REACT) begin
            state_d        = ST_RESULT;
            react_ms_d     = MAX_REACT;
            result_valid_d = 1'b1;
            timed_out_d    = 1'b1;
          end else begin
            react_cnt_d = react_inc;
          end
        end
      end

      ST_RESULT: begin
        if (press) begin
          state_d     = ST_IDLE;
          timed_out_d = 1'b0;
        end
      end

      ST_FAULT: begin
        ledr_d = '0;
        if (press) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ledr_d  = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset to the idle values.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      trigger_q      <= 1'b0;
      lfsr_q         <= 14'd1;
      step_cnt_q     <= 16'd0;
      hold_cnt_q     <= 32'd0;
      hold_target_q  <= 32'd0;
      react_cnt_q    <= '0;
      ledr_q         <= '0;
      react_ms_q     <= '0;
      result_valid_q <= 1'b0;
      best_ms_q      <= '1;
      timed_out_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      trigger_q      <= trigger;
      lfsr_q         <= lfsr_d;
      step_cnt_q     <= step_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_target_q  <= hold_target_d;
      react_cnt_q    <= react_cnt_d;
      ledr_q         <= ledr_d;
      react_ms_q     <= react_ms_d;
      result_valid_q <= result_valid_d;
      best_ms_q      <= best_ms_d;
      timed_out_q    <= timed_out_d;
    end
  end

  assign ledr         = ledr_q;
  assign react_ms     = react_ms_q;
  assign result_valid = result_valid_q;
  assign best_ms      = best_ms_q;
  assign timed_out    = timed_out_q;
  assign false_start  = (state_q == ST_FAULT);
  assign busy         = (state_q == ST_LIGHTS) || (state_q == ST_DELAY) ||
                        (state_q == ST_TIMING);
  assign state        = state_q;

endmodule
`default_nettype wire
